memwb_pipe: RTL
===============

MEMWB_PIPE -- requirements
Module: memwb_pipe

Interface
REQ-001 SHALL have parameter RW, default 16: data and address width, a multiple of 8, at least 16.
REQ-002 SHALL have parameter REGNO, default 8: number of register write-enable lines, one-hot per register.
REQ-003 SHALL have parameter DEPTH, default 4: maximum number of in-flight memory transactions, a power of two, at least 2.
REQ-004 SHALL have ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_submit  in  1  upstream offers an op.
- o_ready  out  1  op is accepted this cycle.
- i_data  in  RW  ALU result or store data.
- i_addr  in  RW  memory address.
- i_reg_ie  in  REGNO  destination register one-hot.
- i_mem_access  in  1  op is a memory op.
- i_mem_we  in  1  op is a store.
- i_mem_byte  in  1  byte-size access.
- i_mem_sext  in  1  sign-extend a byte load.
- o_reg_ie  out  REGNO  register write enable.
- o_reg_data  out  RW  writeback data.
- o_mem_req  out  1  memory request valid.
- o_mem_addr  out  RW  request address.
- o_mem_data  out  RW  store data.
- o_mem_we  out  1  request is a write.
- o_mem_sel  out  RW/8  byte-lane select.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  in-order response.
- i_mem_data  in  RW  read data.
- o_busy  out  1  occupancy is not 0.
- o_err  out  1  sticky unexpected-response flag.

Function
REQ-005 SHALL accept an op when i_submit and o_ready are both high in the same cycle.
REQ-006 SHALL hold o_ready low in any of these cases:
- o_mem_req is high and i_mem_gnt is low.
- occupancy equals DEPTH.
- i_submit is high, i_mem_access is low, and occupancy is not 0. This keeps writeback in order.
REQ-007 SHALL, on an accepted memory op, do both of the following at the next rising edge:
- register the request and raise o_mem_req.
- push the tuple {reg_ie, byte, sext, lane, we} into the pending FIFO.
REQ-008 SHALL hold o_mem_req, o_mem_addr, o_mem_data, o_mem_we and o_mem_sel stable until the cycle in which i_mem_gnt is high. o_mem_req SHALL then drop unless a new memory op is accepted in that same cycle, in which case the new request is loaded back-to-back.
REQ-009 SHALL define lane as i_addr[log2(RW/8)-1:0] and pass o_mem_addr as i_addr unmodified.
REQ-010 SHALL set o_mem_sel to all ones for a word access. For a byte access it SHALL be one-hot at bit lane. For a byte store, o_mem_data SHALL be i_data[7:0] replicated across all lanes.
REQ-011 SHALL, on i_mem_rvalid with occupancy not 0, pop the FIFO head. If the head is a load with nonzero reg_ie, it SHALL in that same cycle, combinationally:
- drive o_reg_ie equal to the head reg_ie.
- drive o_reg_data equal to i_mem_data for a word load.
- for a byte load, drive o_reg_data equal to byte lane of i_mem_data, zero-extended when sext=0 and sign-extended when sext=1.
REQ-012 SHALL pop store responses without writing back (o_reg_ie = 0).
REQ-013 SHALL, on an accepted non-memory op with nonzero i_reg_ie, drive o_reg_ie = i_reg_ie and o_reg_data = i_data in the same cycle, with zero latency.
REQ-014 SHALL drive o_reg_ie to all zeros in every other cycle. o_reg_data is don't-care when o_reg_ie is 0.
REQ-015 SHALL update occupancy as follows: +1 on push, -1 on pop, unchanged on a simultaneous push and pop. The FIFO pointers SHALL wrap modulo DEPTH.
REQ-016 SHALL accept a push when occupancy equals DEPTH-1 and a pop occurs in the same cycle. Full SHALL never be reached through that path.
REQ-017 SHALL, on i_mem_rvalid with occupancy 0, set o_err high until reset, with no writeback and no pointer change.
REQ-018 SHALL drive o_busy high whenever occupancy is not 0.

Reset
REQ-019 SHALL, while i_rst_n is low, immediately and asynchronously clear:
- o_mem_req
- occupancy
- FIFO pointers
- o_err
REQ-020 SHALL reset the registered request fields to 0. o_reg_ie SHALL be 0 during reset.
REQ-021 SHALL discard in-flight transactions on reset mid-operation. A response arriving after release SHALL trigger REQ-017.
REQ-022 SHALL NOT accept an op in the first cycle after release of i_rst_n while i_submit is low. There SHALL be no spurious o_mem_req after release.

Verification (RW=16, REGNO=8, DEPTH=4)
REQ-023 SHALL cover: a non-memory op with i_data=0x1234 and i_reg_ie=0x04 -> o_reg_ie=0x04 and o_reg_data=0x1234 in the same cycle, with no o_mem_req.
REQ-024 SHALL cover: a byte load at addr=0x0011 with sext=1, i_reg_ie=0x02, and a response of 0x80FF -> o_mem_sel=2'b10; writeback o_reg_data=0xFF80, o_reg_ie=0x02.
REQ-025 SHALL cover: four word loads with i_mem_gnt held high and i_mem_rvalid held low -> o_ready low on the fifth submit and o_busy=1. One response then causes o_ready to rise in the same cycle as the response.
REQ-026 SHALL cover: a byte store of i_data=0x00AB at addr=0x0000 with i_mem_gnt stalled 3 cycles -> o_mem_data=0xABAB and o_mem_sel=2'b01 held stable for all 4 cycles; the response produces no writeback.
REQ-027 SHALL cover: a non-memory op submitted while one load is pending -> o_ready low until that load's response, then accepted; register writes appear in program order.
REQ-028 SHALL cover: i_rst_n pulsed low with 2 loads pending, then one i_mem_rvalid after release -> o_err=1, o_reg_ie=0, o_busy=0.

Source files
------------

// File: rtl/memwb_pipe.sv
// Memory/writeback pipeline stage.
// Issues one memory request at a time to an in-order memory port and tracks
// up to DEPTH outstanding transactions in a pending FIFO. Responses pop the
// FIFO and produce register writeback combinationally. Non-memory ops write
// back with zero latency, but only when nothing is pending, so writes stay in
// program order.
module memwb_pipe #(
    parameter int unsigned RW    = 16,
    parameter int unsigned REGNO = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_submit,
    output logic               o_ready,
    input  logic [RW-1:0]      i_data,
    input  logic [RW-1:0]      i_addr,
    input  logic [REGNO-1:0]   i_reg_ie,
    input  logic               i_mem_access,
    input  logic               i_mem_we,
    input  logic               i_mem_byte,
    input  logic               i_mem_sext,
    output logic [REGNO-1:0]   o_reg_ie,
    output logic [RW-1:0]      o_reg_data,
    output logic               o_mem_req,
    output logic [RW-1:0]      o_mem_addr,
    output logic [RW-1:0]      o_mem_data,
    output logic               o_mem_we,
    output logic [RW/8-1:0]    o_mem_sel,
    input  logic               i_mem_gnt,
    input  logic               i_mem_rvalid,
    input  logic [RW-1:0]      i_mem_data,
    output logic               o_busy,
    output logic               o_err
);

    localparam int unsigned NB = RW / 8;
    localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Occupancy, pointers and sticky error
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;

    // Registered memory request
    logic             req_q, req_d;
    logic [RW-1:0]    addr_q, addr_d;
    logic [RW-1:0]    mdata_q, mdata_d;
    logic             we_q, we_d;
    logic [NB-1:0]    sel_q, sel_d;

    // Pending FIFO storage: {reg_ie, byte, sext, lane, we}
    logic [REGNO-1:0] fifo_ie_q   [DEPTH];
    logic             fifo_byte_q [DEPTH];
    logic             fifo_sext_q [DEPTH];
    logic [LW-1:0]    fifo_lane_q [DEPTH];
    logic             fifo_we_q   [DEPTH];

    // Handshake and control
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             accept;
    logic             alu_wb;
    logic             stall_req;
    logic             full_block;
    logic             order_block;
    logic [LW-1:0]    lane_in;

    // FIFO head view
    logic [REGNO-1:0] head_ie;
    logic             head_byte;
    logic             head_sext;
    logic [LW-1:0]    head_lane;
    logic             head_we;
    logic [7:0]       head_rbyte;
    logic [RW-1:0]    load_data;

    // Handshake: a pending ungranted request, a full FIFO with no pop, or a
    // non-memory op behind outstanding loads all block acceptance.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        pop         = i_mem_rvalid && !empty;
        stall_req   = req_q && !i_mem_gnt;
        full_block  = full && !pop;
        order_block = i_submit && !i_mem_access && !empty;
        o_ready     = i_rst_n && !stall_req && !full_block && !order_block;
        accept      = i_submit && o_ready;
        push        = accept && i_mem_access;
        alu_wb      = accept && !i_mem_access;
        lane_in     = i_addr[LW-1:0];
    end

    // Next request: load on accept (back-to-back when granted), drop on grant
    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        mdata_d = mdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        if (push) begin
            req_d  = 1'b1;
            addr_d = i_addr;
            we_d   = i_mem_we;
            if (i_mem_byte) begin
                sel_d = NB'(1) << lane_in;
            end else begin
                sel_d = '1;
            end
            if (i_mem_byte && i_mem_we) begin
                mdata_d = {NB{i_data[7:0]}};
            end else begin
                mdata_d = i_data;
            end
        end else if (i_mem_gnt) begin
            req_d = 1'b0;
        end
    end

    // Occupancy, pointer and error next-state
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (i_mem_rvalid && empty) begin
            err_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            mdata_q  <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            mdata_q  <= mdata_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
        end
    end

    // Pending FIFO write; contents are qualified by occupancy, so no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_ie_q[wr_ptr_q]   <= i_reg_ie;
            fifo_byte_q[wr_ptr_q] <= i_mem_byte;
            fifo_sext_q[wr_ptr_q] <= i_mem_sext;
            fifo_lane_q[wr_ptr_q] <= lane_in;
            fifo_we_q[wr_ptr_q]   <= i_mem_we;
        end
    end

    // Head fields and selected response byte
    always_comb begin
        head_ie    = fifo_ie_q[rd_ptr_q];
        head_byte  = fifo_byte_q[rd_ptr_q];
        head_sext  = fifo_sext_q[rd_ptr_q];
        head_lane  = fifo_lane_q[rd_ptr_q];
        head_we    = fifo_we_q[rd_ptr_q];
        head_rbyte = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (LW'(b) == head_lane) begin
                head_rbyte = i_mem_data[b*8 +: 8];
            end
        end
    end

    // Load result formatting: word pass-through or byte zero/sign-extend
    always_comb begin
        load_data = i_mem_data;
        if (head_byte) begin
            if (head_sext) begin
                load_data = {{(RW-8){head_rbyte[7]}}, head_rbyte};
            end else begin
                load_data = {{(RW-8){1'b0}}, head_rbyte};
            end
        end
    end

    // Writeback mux: load response or zero-latency ALU result (mutually exclusive)
    always_comb begin
        o_reg_ie   = '0;
        o_reg_data = '0;
        if (pop && !head_we && (head_ie != '0)) begin
            o_reg_ie   = head_ie;
            o_reg_data = load_data;
        end else if (alu_wb && (i_reg_ie != '0)) begin
            o_reg_ie   = i_reg_ie;
            o_reg_data = i_data;
        end
    end

    assign o_mem_req  = req_q;
    assign o_mem_addr = addr_q;
    assign o_mem_data = mdata_q;
    assign o_mem_we   = we_q;
    assign o_mem_sel  = sel_q;
    assign o_busy     = !empty;
    assign o_err      = err_q;

endmodule
